store_commit_buffer: RTL and testbench
======================================

Name: store_commit_buffer

Overview:
- Store buffer directly downstream of the store unit.
- Holds translated stores in a speculative queue until the commit stage retires them, then moves them to a commit queue that drains in order to the data cache write port.
- Provides page-offset match information so the load unit can stall loads that alias pending stores.
- Sits between the store unit and the D$ request arbiter.

Parameters:
- DEPTH_SPEC, 4, speculative queue entries (power of 2, ≥2)
- DEPTH_COMMIT, 8, commit queue entries (power of 2, ≥2)
- ADDR_W, 56, physical address width
- DATA_W, 64, store data width; byte-enable width is DATA_W/8

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all speculative entries
- valid_i  in  1  store unit presents a translated store
- ready_o  out  1  speculative queue can accept
- paddr_i  in  ADDR_W  store physical address
- data_i  in  DATA_W  store data, byte-aligned
- be_i  in  DATA_W/8  byte enables
- size_i  in  2  access size (0=B, 1=H, 2=W, 3=D)
- commit_i  in  1  retire oldest speculative store
- commit_ready_o  out  1  commit queue can accept
- page_offset_i  in  12  load page offset to check
- page_offset_match_o  out  1  a pending store aliases page_offset_i[11:3]
- no_st_pending_o  out  1  commit queue empty
- empty_o  out  1  both queues empty
- req_o  out  1  D$ write request
- addr_o  out  ADDR_W  request address
- wdata_o  out  DATA_W  request data
- be_o  out  DATA_W/8  request byte enables
- size_o  out  2  request size
- gnt_i  in  1  D$ accepts request

Behaviour:
- Reset (async, rst_i=1):
  - All pointers and counts are cleared; both queues are empty.
  - Outputs: ready_o=1, commit_ready_o=1, req_o=0, no_st_pending_o=1, empty_o=1, page_offset_match_o=0.
  - Data-path outputs are don't-care while req_o=0.
  - Reset mid-drain drops every entry; there is no partial completion.
- Each queue is a circular FIFO with a head pointer, a tail pointer and a count. Pointers wrap modulo depth. Counts are one bit wider than the pointers.
- ready_o = (spec_count != DEPTH_SPEC). It is registered-state only and does not depend on same-cycle commit.
- Write: valid_i && ready_o && !flush_i stores {paddr, data, be, size} at the spec tail. The entry becomes visible next cycle. valid_i with ready_o=0 is dropped; the store unit must not do this.
- Commit: commit_i && spec_count!=0 && commit_ready_o moves the spec head entry to the commit tail.
  - The move completes at the next edge.
  - An entry written in the same cycle cannot be committed in that cycle.
  - commit_i with an empty spec queue is ignored.
  - commit_i with commit_ready_o=0 is an illegal stimulus; the bench asserts it never occurs.
- commit_ready_o = (commit_count != DEPTH_COMMIT). A gnt_i in the same cycle does not free a slot for that cycle.
- Flush: flush_i clears spec_count and sets spec tail = spec head at the next edge. The commit queue is untouched.
  - flush_i && commit_i in the same cycle: the commit is performed first, then the remaining speculative entries are discarded.
  - flush_i && valid_i in the same cycle: the write is dropped.
- Drain:
  - req_o = (commit_count != 0).
  - addr_o, wdata_o, be_o and size_o are driven from the commit head.
  - While req_o=1 && !gnt_i, all request fields hold stable.
  - On req_o && gnt_i, the head pops at the edge. The next entry is presented the following cycle, giving a sustained rate of one store per cycle.
  - A commit into an empty commit queue raises req_o one cycle after commit_i.
- Simultaneous commit and pop: commit_count is unchanged; both pointers advance.
- page_offset_match_o is combinational.
  - It is 1 if any valid entry in either queue has paddr[11:3]==page_offset_i[11:3].
  - An entry being granted in the current cycle still counts.
- no_st_pending_o = (commit_count==0).
- empty_o = (spec_count==0 && commit_count==0).

Test Plan:
- Reset, then 4 stores (paddr 0x1000, 0x1008, 0x1010, 0x1018, be 0xFF): ready_o=0 after the 4th; a 5th valid_i is not accepted; req_o stays 0 with no commit.
- Commit 2 with gnt_i=1 continuous: req_o rises 1 cycle after the first commit_i; addr_o=0x1000 then 0x1008 on consecutive cycles; no_st_pending_o=1 after the 2nd grant.
- 3 speculative stores with flush_i asserted together with commit_i: exactly 1 store drains (the oldest); spec queue empty; empty_o=1 after its grant.
- Commit queue full (8 entries, gnt_i=0): commit_ready_o=0; req_o held with addr_o stable for 5 cycles; one gnt_i → commit_ready_o=1 next cycle.
- Store at paddr 0x2A38 pending: page_offset_i=0xA3C → match=1; 0xA40 → match=0; after the entry drains, 0xA3C → match=0.
- rst_i asserted mid-drain with 3 committed entries: req_o=0 immediately (async); after release empty_o=1 and ready_o=1.

Source files
------------

// File: rtl/store_commit_buffer.sv
// Store buffer: speculative queue of translated stores, moved on retire into a commit queue drained in order to the D$.
// Latency: a write is visible next cycle; a commit into an empty commit queue raises req_o one cycle later.
// Backpressure: ready_o/commit_ready_o come from registered counts only; request fields hold while req_o && !gnt_i.
module store_commit_buffer #(
    parameter int DEPTH_SPEC   = 4,
    parameter int DEPTH_COMMIT = 8,
    parameter int ADDR_W       = 56,
    parameter int DATA_W       = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [ADDR_W-1:0]   paddr_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [1:0]          size_i,
    input  logic                commit_i,
    output logic                commit_ready_o,
    input  logic [11:0]         page_offset_i,
    output logic                page_offset_match_o,
    output logic                no_st_pending_o,
    output logic                empty_o,
    output logic                req_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] be_o,
    output logic [1:0]          size_o,
    input  logic                gnt_i
);

    localparam int BE_W = DATA_W / 8;
    localparam int SP_W = $clog2(DEPTH_SPEC);
    localparam int CM_W = $clog2(DEPTH_COMMIT);

    typedef struct packed {
        logic [ADDR_W-1:0] paddr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
        logic [1:0]        size;
    } entry_t;

    // Speculative queue state
    entry_t            spec_mem_q [DEPTH_SPEC];
    entry_t            spec_mem_d [DEPTH_SPEC];
    logic [SP_W-1:0]   spec_head_q, spec_head_d;
    logic [SP_W-1:0]   spec_tail_q, spec_tail_d;
    logic [SP_W:0]     spec_cnt_q,  spec_cnt_d;

    // Commit queue state
    entry_t            cm_mem_q [DEPTH_COMMIT];
    entry_t            cm_mem_d [DEPTH_COMMIT];
    logic [CM_W-1:0]   cm_head_q, cm_head_d;
    logic [CM_W-1:0]   cm_tail_q, cm_tail_d;
    logic [CM_W:0]     cm_cnt_q,  cm_cnt_d;

    logic   spec_wr;
    logic   commit_fire;
    logic   pop;
    entry_t wr_entry;
    entry_t head_entry;

    // Only page-offset bits [11:3] take part in the alias check
    logic   unused_po_bits;
    assign unused_po_bits = ^page_offset_i[2:0];

    assign ready_o        = (spec_cnt_q != (SP_W+1)'(DEPTH_SPEC));
    assign commit_ready_o = (cm_cnt_q != (CM_W+1)'(DEPTH_COMMIT));
    assign req_o          = (cm_cnt_q != '0);
    assign no_st_pending_o = (cm_cnt_q == '0);
    assign empty_o        = (spec_cnt_q == '0) && (cm_cnt_q == '0);

    // A flush in the same cycle kills the incoming write
    assign spec_wr     = valid_i && ready_o && !flush_i;
    assign commit_fire = commit_i && (spec_cnt_q != '0) && commit_ready_o;
    assign pop         = req_o && gnt_i;

    assign wr_entry = '{paddr: paddr_i, data: data_i, be: be_i, size: size_i};

    assign head_entry = cm_mem_q[cm_head_q];
    assign addr_o     = head_entry.paddr;
    assign wdata_o    = head_entry.data;
    assign be_o       = head_entry.be;
    assign size_o     = head_entry.size;

    // Speculative queue next state: write at tail, commit from head, flush drops what remains after the commit
    always_comb begin
        spec_mem_d  = spec_mem_q;
        spec_head_d = spec_head_q + SP_W'(commit_fire);
        spec_tail_d = spec_tail_q + SP_W'(spec_wr);
        spec_cnt_d  = spec_cnt_q + (SP_W+1)'(spec_wr) - (SP_W+1)'(commit_fire);
        if (spec_wr) begin
            spec_mem_d[spec_tail_q] = wr_entry;
        end
        if (flush_i) begin
            spec_tail_d = spec_head_d;
            spec_cnt_d  = '0;
        end
    end

    // Commit queue next state: push the retired spec head, pop on grant; both in one cycle leave the count unchanged
    always_comb begin
        cm_mem_d  = cm_mem_q;
        cm_head_d = cm_head_q + CM_W'(pop);
        cm_tail_d = cm_tail_q + CM_W'(commit_fire);
        cm_cnt_d  = cm_cnt_q + (CM_W+1)'(commit_fire) - (CM_W+1)'(pop);
        if (commit_fire) begin
            cm_mem_d[cm_tail_q] = spec_mem_q[spec_head_q];
        end
    end

    // Alias check over every live entry of both queues; the entry being granted this cycle is still live
    always_comb begin
        logic [SP_W-1:0] sp_off;
        logic [CM_W-1:0] cm_off;
        page_offset_match_o = 1'b0;
        sp_off = '0;
        cm_off = '0;
        for (int j = 0; j < DEPTH_SPEC; j++) begin
            sp_off = SP_W'(j) - spec_head_q;
            if (({1'b0, sp_off} < spec_cnt_q) &&
                (spec_mem_q[j].paddr[11:3] == page_offset_i[11:3])) begin
                page_offset_match_o = 1'b1;
            end
        end
        for (int j = 0; j < DEPTH_COMMIT; j++) begin
            cm_off = CM_W'(j) - cm_head_q;
            if (({1'b0, cm_off} < cm_cnt_q) &&
                (cm_mem_q[j].paddr[11:3] == page_offset_i[11:3])) begin
                page_offset_match_o = 1'b1;
            end
        end
    end

    // State registers; reset empties both queues outright, dropping any in-flight drain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j < DEPTH_SPEC; j++) begin
                spec_mem_q[j] <= '0;
            end
            for (int j = 0; j < DEPTH_COMMIT; j++) begin
                cm_mem_q[j] <= '0;
            end
            spec_head_q <= '0;
            spec_tail_q <= '0;
            spec_cnt_q  <= '0;
            cm_head_q   <= '0;
            cm_tail_q   <= '0;
            cm_cnt_q    <= '0;
        end else begin
            spec_mem_q  <= spec_mem_d;
            cm_mem_q    <= cm_mem_d;
            spec_head_q <= spec_head_d;
            spec_tail_q <= spec_tail_d;
            spec_cnt_q  <= spec_cnt_d;
            cm_head_q   <= cm_head_d;
            cm_tail_q   <= cm_tail_d;
            cm_cnt_q    <= cm_cnt_d;
        end
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: fill, commit/drain, flush+commit, full commit queue, alias match, async reset.
// Inputs change 1 ns after each rising edge; outputs are checked at that same point, away from the edge.
// No DUT-event waits: every phase runs a fixed number of cycles.
module tb_store_commit_buffer;

    localparam int ADDR_W = 56;
    localparam int DATA_W = 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [ADDR_W-1:0] paddr_i;
    logic [DATA_W-1:0] data_i;
    logic [7:0]        be_i;
    logic [1:0]        size_i;
    logic              commit_i;
    logic              commit_ready_o;
    logic [11:0]       page_offset_i;
    logic              page_offset_match_o;
    logic              no_st_pending_o;
    logic              empty_o;
    logic              req_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wdata_o;
    logic [7:0]        be_o;
    logic [1:0]        size_o;
    logic              gnt_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    store_commit_buffer #(
        .DEPTH_SPEC(4), .DEPTH_COMMIT(8), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i), .size_i(size_i),
        .commit_i(commit_i), .commit_ready_o(commit_ready_o),
        .page_offset_i(page_offset_i), .page_offset_match_o(page_offset_match_o),
        .no_st_pending_o(no_st_pending_o), .empty_o(empty_o),
        .req_o(req_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .size_o(size_o),
        .gnt_i(gnt_i)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one store for one cycle
    task automatic put_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        valid_i = 1'b1;
        paddr_i = a;
        data_i  = d;
        be_i    = 8'hFF;
        size_i  = 2'd3;
        step();
        valid_i = 1'b0;
    endtask

    // Committing into a full commit queue must never be driven
    always @(negedge clk_i) begin
        if (!rst_i && commit_i && !commit_ready_o) begin
            check_val("illegal_commit", 64'd1, 64'd0);
        end
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; paddr_i = '0; data_i = '0;
        be_i = '0; size_i = '0; commit_i = 1'b0; page_offset_i = '0; gnt_i = 1'b0;
        step();
        step();
        check_val("rst_ready", 64'(ready_o), 64'd1);
        check_val("rst_commit_ready", 64'(commit_ready_o), 64'd1);
        check_val("rst_req", 64'(req_o), 64'd0);
        check_val("rst_no_st", 64'(no_st_pending_o), 64'd1);
        check_val("rst_empty", 64'(empty_o), 64'd1);
        check_val("rst_match", 64'(page_offset_match_o), 64'd0);
        rst_i = 1'b0;
        step();

        // Fill the speculative queue; a 5th store must be dropped
        for (int k = 0; k < 4; k++) put_store(56'h1000 + 56'(8 * k), 64'hA0 + 64'(k));
        check_val("full_ready", 64'(ready_o), 64'd0);
        put_store(56'h1020, 64'hDEAD);
        check_val("fifth_ready", 64'(ready_o), 64'd0);
        check_val("no_commit_req", 64'(req_o), 64'd0);
        check_val("not_empty", 64'(empty_o), 64'd0);

        // Commit two with continuous grant
        gnt_i = 1'b1;
        commit_i = 1'b1;
        check_val("req_before_commit", 64'(req_o), 64'd0);
        step();
        check_val("req_rise", 64'(req_o), 64'd1);
        check_val("addr0", 64'(addr_o), 64'h1000);
        check_val("wdata0", wdata_o, 64'hA0);
        check_val("be0", 64'(be_o), 64'hFF);
        check_val("size0", 64'(size_o), 64'd3);
        step();
        commit_i = 1'b0;
        check_val("addr1", 64'(addr_o), 64'h1008);
        check_val("req1", 64'(req_o), 64'd1);
        step();
        check_val("no_st_after2", 64'(no_st_pending_o), 64'd1);
        check_val("req_low_after2", 64'(req_o), 64'd0);
        check_val("ready_after2", 64'(ready_o), 64'd1);

        // Commit the remaining two; the dropped 5th store must not show up
        commit_i = 1'b1;
        step();
        check_val("addr2", 64'(addr_o), 64'h1010);
        step();
        commit_i = 1'b0;
        check_val("addr3", 64'(addr_o), 64'h1018);
        step();
        check_val("empty_after4", 64'(empty_o), 64'd1);
        gnt_i = 1'b0;

        // Three stores, then flush together with commit: only the oldest survives
        for (int k = 0; k < 3; k++) put_store(56'h3000 + 56'(8 * k), 64'hB0 + 64'(k));
        commit_i = 1'b1;
        flush_i  = 1'b1;
        step();
        commit_i = 1'b0;
        flush_i  = 1'b0;
        check_val("flush_req", 64'(req_o), 64'd1);
        check_val("flush_addr", 64'(addr_o), 64'h3000);
        check_val("flush_spec_ready", 64'(ready_o), 64'd1);
        check_val("flush_not_empty", 64'(empty_o), 64'd0);
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        check_val("flush_empty", 64'(empty_o), 64'd1);
        check_val("flush_req_low", 64'(req_o), 64'd0);
        step();
        check_val("flush_no_more", 64'(req_o), 64'd0);

        // Fill the commit queue with eight entries and no grant
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) put_store(56'h4000 + 56'(8 * (4 * r + k)), 64'hC0 + 64'(4 * r + k));
            commit_i = 1'b1;
            for (int k = 0; k < 4; k++) step();
            commit_i = 1'b0;
        end
        check_val("cq_full", 64'(commit_ready_o), 64'd0);
        for (int k = 0; k < 5; k++) begin
            check_val("hold_req", 64'(req_o), 64'd1);
            check_val("hold_addr", 64'(addr_o), 64'h4000);
            step();
        end
        gnt_i = 1'b1;
        check_val("gnt_same_cycle", 64'(commit_ready_o), 64'd0);
        step();
        gnt_i = 1'b0;
        check_val("cq_slot_freed", 64'(commit_ready_o), 64'd1);
        check_val("cq_next_addr", 64'(addr_o), 64'h4008);
        gnt_i = 1'b1;
        for (int k = 0; k < 7; k++) step();
        gnt_i = 1'b0;
        check_val("cq_drained", 64'(empty_o), 64'd1);

        // Page-offset alias match
        put_store(56'h2A38, 64'h55);
        page_offset_i = 12'hA3C;
        #1 check_val("match_spec", 64'(page_offset_match_o), 64'd1);
        page_offset_i = 12'hA40;
        #1 check_val("nomatch_spec", 64'(page_offset_match_o), 64'd0);
        page_offset_i = 12'hA3C;
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        check_val("match_commit", 64'(page_offset_match_o), 64'd1);
        gnt_i = 1'b1;
        #1 check_val("match_while_gnt", 64'(page_offset_match_o), 64'd1);
        step();
        gnt_i = 1'b0;
        check_val("match_after_drain", 64'(page_offset_match_o), 64'd0);

        // Reset in the middle of a drain with three committed entries
        for (int k = 0; k < 3; k++) put_store(56'h5000 + 56'(8 * k), 64'hD0 + 64'(k));
        commit_i = 1'b1;
        for (int k = 0; k < 3; k++) step();
        commit_i = 1'b0;
        gnt_i = 1'b1;
        check_val("pre_rst_req", 64'(req_o), 64'd1);
        #2 rst_i = 1'b1;
        #1 check_val("rst_async_req", 64'(req_o), 64'd0);
        step();
        rst_i = 1'b0;
        gnt_i = 1'b0;
        step();
        check_val("post_rst_empty", 64'(empty_o), 64'd1);
        check_val("post_rst_ready", 64'(ready_o), 64'd1);
        check_val("post_rst_req", 64'(req_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
